stream_arbiter: RTL and testbench

Round-robin arbiter that shares one valid/ready output stream between NUM_IN requesting streams, with a single registered output stage. Sits upstream of a consumer that can only take one stream at a time, e.g. feeding one side of a `stream_join` from several producers. Optionally holds the grant for a whole packet, delimited by `last`, so packets are never interleaved.

---
 rtl/stream_arbiter.sv | 156 +++++++++++++++
 tb/tb_stream_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_arbiter.sv
// Round-robin valid/ready stream arbiter with one registered output slot.
// Define STREAM_ARB_PACKET_LOCK_EN to hold the grant until the beat with last=1.
module stream_arbiter #(
    parameter int NUM_IN     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = $clog2(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_IN-1:0]            i_valid,
    output logic [NUM_IN-1:0]            i_ready,
    input  logic [NUM_IN*DATA_WIDTH-1:0] i_data,
    input  logic [NUM_IN-1:0]            i_last,
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         o_last,
    output logic [SEL_WIDTH-1:0]         o_sel
);

    typedef enum logic {
        ARB,
        LOCK
    } state_e;

    localparam logic [SEL_WIDTH:0]   NUM_W    = (SEL_WIDTH+1)'(NUM_IN);
    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_IN - 1);
    localparam logic [SEL_WIDTH-1:0] SEL_ONE  = SEL_WIDTH'(1);

    state_e                 state_q, state_d;
    logic [SEL_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SEL_WIDTH-1:0]   lock_idx_q, lock_idx_d;
    logic                   o_valid_q, o_valid_d;
    logic [DATA_WIDTH-1:0]  o_data_q, o_data_d;
    logic                   o_last_q, o_last_d;
    logic [SEL_WIDTH-1:0]   o_sel_q, o_sel_d;

    logic                   load_ok;
    logic                   xfer;
    logic                   cand_found;
    logic [SEL_WIDTH-1:0]   cand_idx;
    logic [SEL_WIDTH-1:0]   grant_idx;
    logic [SEL_WIDTH:0]     probe;
    logic [DATA_WIDTH-1:0]  data_arr [NUM_IN];

    // Wraps at NUM_IN, which need not be a power of two.
    function automatic logic [SEL_WIDTH-1:0] wrap_inc(
        input logic [SEL_WIDTH-1:0] idx
    );
        return (idx == LAST_IDX) ? '0 : idx + SEL_ONE;
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_IN; k++) begin
            data_arr[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Scan from the far end so the nearest requester to rr_ptr wins.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        probe      = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            probe = {1'b0, rr_ptr_q} + (SEL_WIDTH+1)'(i);
            if (probe >= NUM_W) begin
                probe = probe - NUM_W;
            end
            if (i_valid[probe[SEL_WIDTH-1:0]]) begin
                cand_found = 1'b1;
                cand_idx   = probe[SEL_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        o_valid_d  = o_valid_q;
        o_data_d   = o_data_q;
        o_last_d   = o_last_q;
        o_sel_d    = o_sel_q;
        i_ready    = '0;
        xfer       = 1'b0;
        grant_idx  = cand_idx;
        load_ok    = !o_valid_q || o_ready;

        unique case (state_q)
            ARB: begin
                if (load_ok && cand_found) begin
                    xfer      = 1'b1;
                    grant_idx = cand_idx;
                    rr_ptr_d  = wrap_inc(cand_idx);
`ifdef STREAM_ARB_PACKET_LOCK_EN
                    if (!i_last[cand_idx]) begin
                        state_d    = LOCK;
                        lock_idx_d = cand_idx;
                    end
`endif
                end
            end
            LOCK: begin
                if (load_ok && i_valid[lock_idx_q]) begin
                    xfer      = 1'b1;
                    grant_idx = lock_idx_q;
                    if (i_last[lock_idx_q]) begin
                        state_d  = ARB;
                        rr_ptr_d = wrap_inc(lock_idx_q);
                    end
                end
            end
        endcase

        if (xfer) begin
            i_ready[grant_idx] = reset_n;
            o_valid_d          = 1'b1;
            o_data_d           = data_arr[grant_idx];
            o_last_d           = i_last[grant_idx];
            o_sel_d            = grant_idx;
        end else if (o_ready) begin
            o_valid_d = 1'b0;
            o_data_d  = '0;
            o_last_d  = 1'b0;
            o_sel_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ARB;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_last_q   <= 1'b0;
            o_sel_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
            o_last_q   <= o_last_d;
            o_sel_q    <= o_sel_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_last  = o_last_q;
    assign o_sel   = o_sel_q;

    a_ready_onehot: assert property (@(posedge clk) $onehot0(i_ready));

endmodule

// File: tb/tb_stream_arbiter.sv
// Scoreboard bench for stream_arbiter: a reference arbiter predicts grants,
// expected beats are queued on acceptance and compared when they leave.
module tb_stream_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   i_valid;
    logic [N-1:0]   i_ready;
    logic [N*W-1:0] i_data;
    logic [N-1:0]   i_last;
    logic           o_valid;
    logic           o_ready;
    logic [W-1:0]   o_data;
    logic           o_last;
    logic [1:0]     o_sel;

    stream_arbiter #(
        .NUM_IN     (N),
        .DATA_WIDTH (W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_sel   (o_sel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic [1:0] s;
    } beat_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    beat_t      exp_q[$];
    logic [8:0] src[N][$];
    logic [1:0] sel_log[$];
    logic       last_log[$];
    bit         m_locked;
    int         m_ptr;
    int         m_lock;
    int         exp_sel[6];
    int         exp_lst[6];

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic bit busy();
        bit b = exp_q.size() > 0;
        for (int k = 0; k < N; k++) begin
            if (src[k].size() > 0) b = 1'b1;
        end
        return b;
    endfunction

    task automatic drive();
        logic [8:0] e;
        for (int k = 0; k < N; k++) begin
            if (src[k].size() > 0) begin
                e = src[k][0];
                i_valid[k]         = 1'b1;
                i_data[k*W +: W]   = e[8:1];
                i_last[k]          = e[0];
            end else begin
                i_valid[k]         = 1'b0;
                i_data[k*W +: W]   = '0;
                i_last[k]          = 1'b0;
            end
        end
    endtask

    // Entered and left at a negedge; inputs change there, checks at +1.
    task automatic cycle();
        logic [N-1:0] er;
        int           g;
        bit           had;
        bit           load_ok;
        beat_t        b;
        drive();
        #1;
        had = exp_q.size() > 0;
        chk("o_valid", o_valid, had);
        if (had) begin
            b = exp_q[0];
            chk("o_data", o_data, b.d);
            chk("o_last", o_last, b.l);
            chk("o_sel", o_sel, b.s);
            if (o_ready) begin
                void'(exp_q.pop_front());
                sel_log.push_back(o_sel);
                last_log.push_back(o_last);
            end
        end else begin
            chk("o_data_idle", o_data, 0);
        end
        er = '0;
        g  = -1;
        if (!reset_n) begin
            chk("i_ready_rst", i_ready, 0);
            exp_q.delete();
            m_locked = 1'b0;
            m_ptr    = 0;
            m_lock   = 0;
        end else begin
            load_ok = !had || o_ready;
            if (load_ok) begin
                if (m_locked) begin
                    if (i_valid[m_lock]) g = m_lock;
                end else begin
                    for (int off = 0; off < N && g < 0; off++) begin
                        if (i_valid[(m_ptr + off) % N]) g = (m_ptr + off) % N;
                    end
                end
            end
            if (g >= 0) begin
                er[g] = 1'b1;
                b.d   = i_data[g*W +: W];
                b.l   = i_last[g];
                b.s   = 2'(g);
                exp_q.push_back(b);
                void'(src[g].pop_front());
                if (m_locked) begin
                    if (i_last[g]) begin
                        m_locked = 1'b0;
                        m_ptr    = (g + 1) % N;
                    end
                end else begin
                    m_ptr = (g + 1) % N;
`ifdef STREAM_ARB_PACKET_LOCK_EN
                    if (!i_last[g]) begin
                        m_locked = 1'b1;
                        m_lock   = g;
                    end
`endif
                end
            end
            chk("i_ready", i_ready, er);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_until_idle(input int max);
        int n = 0;
        while (busy() && n < max) begin
            cycle();
            n++;
        end
        chk("drain_done", busy(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
`ifdef STREAM_ARB_PACKET_LOCK_EN
        exp_sel = '{2, 2, 2, 0, 0, 0};
        exp_lst = '{0, 0, 1, 1, 1, 1};
`else
        exp_sel = '{2, 0, 2, 0, 2, 0};
        exp_lst = '{0, 1, 0, 1, 1, 1};
`endif
        reset_n  = 1'b0;
        o_ready  = 1'b1;
        i_valid  = '0;
        i_data   = '0;
        i_last   = '0;
        m_locked = 1'b0;
        m_ptr    = 0;
        m_lock   = 0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < 3; j++) begin
                src[k].push_back({8'(8'h10 + k), 1'b1});
            end
        end
        @(negedge clk);

        repeat (2) cycle();
        reset_n = 1'b1;

        sel_log.delete();
        last_log.delete();
        repeat (9) cycle();
        chk("fair_beats", sel_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < sel_log.size()) chk("fair_sel", sel_log[i], i % 4);
        end

        o_ready = 1'b0;
        repeat (5) cycle();
        o_ready = 1'b1;
        run_until_idle(40);

        sel_log.delete();
        last_log.delete();
        src[2].push_back({8'hA0, 1'b0});
        src[2].push_back({8'hA1, 1'b0});
        src[2].push_back({8'hA2, 1'b1});
        cycle();
        for (int j = 0; j < 3; j++) begin
            src[0].push_back({8'(8'hB0 + j), 1'b1});
        end
        run_until_idle(20);
        chk("pkt_beats", sel_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < sel_log.size()) begin
                chk("pkt_sel", sel_log[i], exp_sel[i]);
                chk("pkt_last", last_log[i], exp_lst[i]);
            end
        end

        for (int j = 0; j < 4; j++) begin
            src[1].push_back({8'(8'hC0 + j), j == 3});
        end
        cycle();
        src[0].push_back({8'hD0, 1'b1});
        src[0].push_back({8'hD1, 1'b1});
        cycle();
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        sel_log.delete();
        last_log.delete();
        run_until_idle(20);
        chk("rst_beats_ge2", sel_log.size() >= 2, 1);
        if (sel_log.size() >= 2) begin
            chk("rst_first_sel", sel_log[0], 0);
            chk("rst_second_sel", sel_log[1], 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
